mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_pkg.sv | 26 ++
 rtl/mem_arbiter_starve_counter.sv | 44 ++++
 rtl/mem_arbiter.sv | 174 +++++++++++++++++
 tb/tb_mem_arbiter.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the memory arbiter: state encoding, default
// widths and the starvation-counter width helper.
package mem_arbiter_pkg;

  localparam int DEF_ADDR_W     = 10;
  localparam int DEF_DATA_W     = 32;
  localparam int DEF_STARVE_MAX = 4;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } arb_state_e;

  // Bits needed to hold 0..max_val inclusive (never less than one bit).
  function automatic int cnt_width(input int max_val);
    int w;
    if (max_val < 1) begin
      w = 1;
    end else begin
      w = $clog2(max_val + 1);
    end
    return w;
  endfunction

endpackage

// File: rtl/mem_arbiter_starve_counter.sv
// Saturating count of data grants that went by while a fetch was waiting.
module starve_counter import mem_arbiter_pkg::*; #(
  parameter int MAX   = DEF_STARVE_MAX,
  parameter int CNT_W = cnt_width(DEF_STARVE_MAX)
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic full
);

  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: clear wins over increment; increment stops at MAX.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = {CNT_W{1'b0}};
    end else if (inc && (cnt_q != MAX_C)) begin
      cnt_d = cnt_q + CNT_W'(1'b1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Fetch gets priority once the count has reached the limit.
  always_comb begin
    full = (cnt_q == MAX_C);
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates a single-port memory between instruction fetch and data
// accesses. Grants are combinational; read data returns one cycle later.
// After halt, fetch is shut off, in-flight responses drain, and the block
// parks in HALTED until reset while data accesses keep being served.
module mem_arbiter import mem_arbiter_pkg::*; #(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int STARVE_MAX = DEF_STARVE_MAX
) (
  input  logic              clk1,
  input  logic              rst,
  input  logic              halt,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_gnt,
  output logic              dm_rvalid,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              halted
);

  localparam int CNT_W = cnt_width(STARVE_MAX);

  arb_state_e state_q;
  arb_state_e state_d;
  logic       if_pend_q;
  logic       if_pend_d;
  logic       dm_pend_q;
  logic       dm_pend_d;

  logic       starve_full_s;
  logic       starve_inc_s;
  logic       starve_clr_s;
  logic       fetch_ok_s;
  logic       if_gnt_s;
  logic       dm_gnt_s;

  // Grant selection: data first, unless fetch has been starved to the limit.
  always_comb begin
    fetch_ok_s = 1'b0;
    if_gnt_s   = 1'b0;
    dm_gnt_s   = 1'b0;
    if (rst) begin
      fetch_ok_s = 1'b0;
      if_gnt_s   = 1'b0;
      dm_gnt_s   = 1'b0;
    end else begin
      // A halt arriving this cycle already blocks fetch.
      fetch_ok_s = (state_q == ST_RUN) && !halt;
      if (if_req && fetch_ok_s && (!dm_req || starve_full_s)) begin
        if_gnt_s = 1'b1;
      end else if (dm_req) begin
        dm_gnt_s = 1'b1;
      end else begin
        if_gnt_s = 1'b0;
        dm_gnt_s = 1'b0;
      end
    end
  end

  // Memory command steered from whichever port won this cycle.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = {ADDR_W{1'b0}};
    mem_wdata = {DATA_W{1'b0}};
    if (dm_gnt_s) begin
      mem_en    = 1'b1;
      mem_we    = dm_we;
      mem_addr  = dm_addr;
      mem_wdata = dm_wdata;
    end else if (if_gnt_s) begin
      mem_en    = 1'b1;
      mem_we    = 1'b0;
      mem_addr  = if_addr;
      mem_wdata = {DATA_W{1'b0}};
    end else begin
      mem_en    = 1'b0;
      mem_we    = 1'b0;
    end
  end

  // Next state and outstanding-read flags.
  always_comb begin
    state_d   = state_q;
    if_pend_d = if_gnt_s;
    dm_pend_d = dm_gnt_s && !dm_we;
    case (state_q)
      ST_RUN: begin
        if (halt) begin
          state_d = ST_DRAIN;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_DRAIN: begin
        if (!if_pend_q && !dm_pend_q) begin
          state_d = ST_HALTED;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      ST_HALTED: begin
        state_d = ST_HALTED;
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  // State and outstanding-read registers.
  always_ff @(posedge clk1) begin
    if (rst) begin
      state_q   <= ST_RUN;
      if_pend_q <= 1'b0;
      dm_pend_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      if_pend_q <= if_pend_d;
      dm_pend_q <= dm_pend_d;
    end
  end

  // Starvation bookkeeping: count data wins against a waiting fetch.
  always_comb begin
    starve_inc_s = dm_gnt_s && if_req;
    starve_clr_s = if_gnt_s || !if_req;
  end

  starve_counter #(
    .MAX   (STARVE_MAX),
    .CNT_W (CNT_W)
  ) u_starve (
    .clk  (clk1),
    .rst  (rst),
    .inc  (starve_inc_s),
    .clr  (starve_clr_s),
    .full (starve_full_s)
  );

  // Responses: a read answered in a reset cycle is dropped; data is zero when idle.
  always_comb begin
    if_gnt    = if_gnt_s;
    dm_gnt    = dm_gnt_s;
    if_rvalid = if_pend_q && !rst;
    dm_rvalid = dm_pend_q && !rst;
    if_rdata  = {DATA_W{1'b0}};
    dm_rdata  = {DATA_W{1'b0}};
    if (if_rvalid) begin
      if_rdata = mem_rdata;
    end else begin
      if_rdata = {DATA_W{1'b0}};
    end
    if (dm_rvalid) begin
      dm_rdata = mem_rdata;
    end else begin
      dm_rdata = {DATA_W{1'b0}};
    end
    halted = (state_q == ST_HALTED);
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed scoreboard bench for mem_arbiter: a driver pushes per-cycle
// command expectations and timed read-response expectations; a monitor
// on the falling edge pops and compares them.
module tb_mem_arbiter;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 32;

  logic              clk1 = 1'b0;
  logic              rst;
  logic              halt;
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;
  logic              dm_req;
  logic              dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic              dm_gnt;
  logic              dm_rvalid;
  logic [DATA_W-1:0] dm_rdata;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              halted;

  mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(4)) dut (
    .clk1(clk1), .rst(rst), .halt(halt),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .halted(halted)
  );

  always #5 clk1 = ~clk1;

  int cyc = 0;
  always @(posedge clk1) cyc <= cyc + 1;

  // Fixed memory contents used by the memory stand-in.
  function automatic logic [31:0] mem_word(input logic [ADDR_W-1:0] a);
    logic [31:0] w;
    case (a)
      10'd0:   w = 32'h2801_000a;
      10'd1:   w = 32'h2802_0014;
      10'd2:   w = 32'h0022_2000;
      10'd3:   w = 32'hfc00_0000;
      10'd5:   w = 32'h0000_0505;
      10'd7:   w = 32'h0000_0707;
      default: w = 32'h5a5a_0000 ^ {22'd0, a};
    endcase
    return w;
  endfunction

  // Memory stand-in: read data one cycle after a read command, junk otherwise.
  always @(posedge clk1) begin
    if (mem_en && !mem_we) mem_rdata <= mem_word(mem_addr);
    else                   mem_rdata <= 32'hbad0_bad0;
  end

  typedef struct {
    int          due;
    logic        ig;
    logic        dg;
    logic        en;
    logic        we;
    logic [9:0]  addr;
    logic [31:0] wdata;
    logic        hl;
  } cyc_exp_t;

  typedef struct {
    int          due;
    logic [31:0] data;
  } rsp_exp_t;

  cyc_exp_t cyc_q[$];
  rsp_exp_t if_q[$];
  rsp_exp_t dm_q[$];
  cyc_exp_t mon_e;
  rsp_exp_t mon_r;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // One cycle of stimulus plus its hand-computed expectations.
  task automatic step(input logic r, input logic h, input logic ir, input logic [9:0] ia,
                      input logic dr, input logic dw, input logic [9:0] da, input logic [31:0] dwd,
                      input logic eig, input logic edg, input logic ehl, input logic [31:0] erd);
    cyc_exp_t e;
    @(posedge clk1);
    #1;
    rst = r; halt = h; if_req = ir; if_addr = ia;
    dm_req = dr; dm_we = dw; dm_addr = da; dm_wdata = dwd;
    e.due   = cyc;
    e.ig    = eig;
    e.dg    = edg;
    e.en    = eig | edg;
    e.we    = edg & dw;
    e.addr  = edg ? da : ia;
    e.wdata = dwd;
    e.hl    = ehl;
    cyc_q.push_back(e);
    // A response falling due in a reset cycle is expected to vanish.
    if (r) begin
      while (if_q.size() > 0 && if_q[$].due == cyc) void'(if_q.pop_back());
      while (dm_q.size() > 0 && dm_q[$].due == cyc) void'(dm_q.pop_back());
    end
    if (eig)        if_q.push_back('{cyc + 1, erd});
    if (edg && !dw) dm_q.push_back('{cyc + 1, erd});
  endtask

  // Monitor: compare commands every cycle and responses whenever presented.
  always @(negedge clk1) begin
    if (cyc_q.size() > 0 && cyc_q[0].due == cyc) begin
      mon_e = cyc_q.pop_front();
      chk("if_gnt", {31'd0, if_gnt}, {31'd0, mon_e.ig});
      chk("dm_gnt", {31'd0, dm_gnt}, {31'd0, mon_e.dg});
      chk("mem_en", {31'd0, mem_en}, {31'd0, mon_e.en});
      chk("mem_we", {31'd0, mem_we}, {31'd0, mon_e.we});
      chk("halted", {31'd0, halted}, {31'd0, mon_e.hl});
      if (mon_e.en) chk("mem_addr", {22'd0, mem_addr}, {22'd0, mon_e.addr});
      if (mon_e.we) chk("mem_wdata", mem_wdata, mon_e.wdata);
    end
    if (if_rvalid) begin
      if (if_q.size() == 0) begin
        chk("if_rvalid_unexpected", {31'd0, if_rvalid}, 32'd0);
      end else begin
        mon_r = if_q.pop_front();
        chk("if_rsp_cycle", cyc, mon_r.due);
        chk("if_rdata", if_rdata, mon_r.data);
      end
    end else begin
      chk("if_rdata_idle", if_rdata, 32'd0);
      if (if_q.size() > 0 && if_q[0].due <= cyc) begin
        chk("if_rvalid_missing", {31'd0, if_rvalid}, 32'd1);
        void'(if_q.pop_front());
      end
    end
    if (dm_rvalid) begin
      if (dm_q.size() == 0) begin
        chk("dm_rvalid_unexpected", {31'd0, dm_rvalid}, 32'd0);
      end else begin
        mon_r = dm_q.pop_front();
        chk("dm_rsp_cycle", cyc, mon_r.due);
        chk("dm_rdata", dm_rdata, mon_r.data);
      end
    end else begin
      chk("dm_rdata_idle", dm_rdata, 32'd0);
      if (dm_q.size() > 0 && dm_q[0].due <= cyc) begin
        chk("dm_rvalid_missing", {31'd0, dm_rvalid}, 32'd1);
        void'(dm_q.pop_front());
      end
    end
  end

  initial begin
    rst = 1'b1; halt = 1'b0; if_req = 1'b0; if_addr = 10'd0;
    dm_req = 1'b0; dm_we = 1'b0; dm_addr = 10'd0; dm_wdata = 32'd0;

    // Reset: requests present but nothing granted.
    step(1'b1, 1'b0, 1'b1, 10'd0, 1'b1, 1'b0, 10'd5, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0);
    step(1'b1, 1'b0, 1'b0, 10'd0, 1'b0, 1'b0, 10'd0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0);

    // Back-to-back fetch of words 0..3.
    step(1'b0, 1'b0, 1'b1, 10'd0, 1'b0, 1'b0, 10'd0, 32'd0, 1'b1, 1'b0, 1'b0, 32'h2801_000a);
    step(1'b0, 1'b0, 1'b1, 10'd1, 1'b0, 1'b0, 10'd0, 32'd0, 1'b1, 1'b0, 1'b0, 32'h2802_0014);
    step(1'b0, 1'b0, 1'b1, 10'd2, 1'b0, 1'b0, 10'd0, 32'd0, 1'b1, 1'b0, 1'b0, 32'h0022_2000);
    step(1'b0, 1'b0, 1'b1, 10'd3, 1'b0, 1'b0, 10'd0, 32'd0, 1'b1, 1'b0, 1'b0, 32'hfc00_0000);
    step(1'b0, 1'b0, 1'b0, 10'd0, 1'b0, 1'b0, 10'd0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0);

    // Data beats fetch; fetch granted the next cycle alongside the load response.
    step(1'b0, 1'b0, 1'b1, 10'd7, 1'b1, 1'b0, 10'd5, 32'd0, 1'b0, 1'b1, 1'b0, 32'h0000_0505);
    step(1'b0, 1'b0, 1'b1, 10'd7, 1'b0, 1'b0, 10'd0, 32'd0, 1'b1, 1'b0, 1'b0, 32'h0000_0707);
    step(1'b0, 1'b0, 1'b0, 10'd0, 1'b0, 1'b0, 10'd0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0);

    // Starvation: four data grants, one fetch, then data resumes.
    for (int i = 0; i < 4; i++)
      step(1'b0, 1'b0, 1'b1, 10'd2, 1'b1, 1'b0, 10'd5, 32'd0, 1'b0, 1'b1, 1'b0, 32'h0000_0505);
    step(1'b0, 1'b0, 1'b1, 10'd2, 1'b1, 1'b0, 10'd5, 32'd0, 1'b1, 1'b0, 1'b0, 32'h0022_2000);
    step(1'b0, 1'b0, 1'b0, 10'd0, 1'b1, 1'b0, 10'd5, 32'd0, 1'b0, 1'b1, 1'b0, 32'h0000_0505);
    step(1'b0, 1'b0, 1'b0, 10'd0, 1'b0, 1'b0, 10'd0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0);

    // Store: write command, no response.
    step(1'b0, 1'b0, 1'b0, 10'd0, 1'b1, 1'b1, 10'd6, 32'd30, 1'b0, 1'b1, 1'b0, 32'd0);
    step(1'b0, 1'b0, 1'b0, 10'd0, 1'b0, 1'b0, 10'd0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0);

    // Halt with a fetch in flight: DRAIN for one cycle, then HALTED.
    step(1'b0, 1'b0, 1'b1, 10'd1, 1'b0, 1'b0, 10'd0, 32'd0, 1'b1, 1'b0, 1'b0, 32'h2802_0014);
    step(1'b0, 1'b1, 1'b1, 10'd1, 1'b0, 1'b0, 10'd0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0);
    step(1'b0, 1'b0, 1'b1, 10'd1, 1'b0, 1'b0, 10'd0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0);
    step(1'b0, 1'b0, 1'b1, 10'd1, 1'b1, 1'b0, 10'd5, 32'd0, 1'b0, 1'b1, 1'b1, 32'h0000_0505);
    step(1'b0, 1'b0, 1'b1, 10'd1, 1'b0, 1'b0, 10'd0, 32'd0, 1'b0, 1'b0, 1'b1, 32'd0);

    // Reset leaves HALTED.
    step(1'b1, 1'b0, 1'b0, 10'd0, 1'b0, 1'b0, 10'd0, 32'd0, 1'b0, 1'b0, 1'b1, 32'd0);

    // Build starvation to 3, reset mid-burst with a load outstanding.
    for (int i = 0; i < 3; i++)
      step(1'b0, 1'b0, 1'b1, 10'd0, 1'b1, 1'b0, 10'd5, 32'd0, 1'b0, 1'b1, 1'b0, 32'h0000_0505);
    step(1'b1, 1'b0, 1'b1, 10'd0, 1'b1, 1'b0, 10'd5, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0);
    // Counter restarted: a full four data grants before fetch wins.
    for (int i = 0; i < 4; i++)
      step(1'b0, 1'b0, 1'b1, 10'd0, 1'b1, 1'b0, 10'd5, 32'd0, 1'b0, 1'b1, 1'b0, 32'h0000_0505);
    step(1'b0, 1'b0, 1'b1, 10'd0, 1'b1, 1'b0, 10'd5, 32'd0, 1'b1, 1'b0, 1'b0, 32'h2801_000a);
    step(1'b0, 1'b0, 1'b0, 10'd0, 1'b0, 1'b0, 10'd0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0);
    step(1'b0, 1'b0, 1'b0, 10'd0, 1'b0, 1'b0, 10'd0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0);

    @(negedge clk1);
    #1;
    chk("if_rsp_left", if_q.size(), 32'd0);
    chk("dm_rsp_left", dm_q.size(), 32'd0);
    chk("cmd_left", cyc_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
